// File: rtl/gemm_dispatch.sv
// Compute-instruction dispatcher for the gemm core. It sequences dependency-token pops,
// the gemm start/done handshake, and then the completion-token pushes.
module gemm_dispatch #(
    parameter int unsigned INS_WIDTH = 128,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INS_WIDTH-1:0] insn_in,
    input  logic                 insn_valid,
    output logic                 insn_ready,
    input  logic                 l2g_dep_valid,
    output logic                 l2g_dep_ready,
    input  logic                 s2g_dep_valid,
    output logic                 s2g_dep_ready,
    output logic                 g2l_dep_valid,
    input  logic                 g2l_dep_ready,
    output logic                 g2s_dep_valid,
    input  logic                 g2s_dep_ready,
    output logic [INS_WIDTH-1:0] gemm_insn,
    output logic                 gemm_start,
    input  logic                 gemm_done,
    output logic                 finish,
    output logic                 err_opcode,
    output logic [CNT_WIDTH-1:0] insn_cnt
);

    localparam logic [2:0] OpGemm   = 3'h2;
    localparam logic [2:0] OpFinish = 3'h3;

    typedef enum logic [2:0] {
        StIdle,
        StPopPrev,
        StPopNext,
        StExec,
        StWait,
        StPushPrev,
        StPushNext
    } state_e;

    state_e                 state_q, state_d;
    logic [INS_WIDTH-1:0]   insn_q, insn_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [2:0] opcode;
    logic       pop_prev, pop_next, push_prev, push_next;
    state_e     push_first;

    assign opcode    = insn_q[2:0];
    assign pop_prev  = insn_q[3];
    assign pop_next  = insn_q[4];
    assign push_prev = insn_q[5];
    assign push_next = insn_q[6];

    always_comb begin
        push_first = StIdle;
        if (push_prev) begin
            push_first = StPushPrev;
        end else if (push_next) begin
            push_first = StPushNext;
        end
    end

    always_comb begin
        state_d = state_q;
        insn_d  = insn_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (insn_valid && insn_ready) begin
                    insn_d = insn_in;
                    if (insn_in[3]) begin
                        state_d = StPopPrev;
                    end else if (insn_in[4]) begin
                        state_d = StPopNext;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StPopPrev: begin
                if (l2g_dep_valid) begin
                    state_d = pop_next ? StPopNext : StExec;
                end
            end
            StPopNext: begin
                if (s2g_dep_valid) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (opcode == OpGemm) begin
                    state_d = StWait;
                end else begin
                    // Bad opcodes still push tokens so the producer queues stay balanced.
                    if (opcode != OpFinish) begin
                        err_d = 1'b1;
                    end
                    state_d = push_first;
                end
            end
            StWait: begin
                if (gemm_done) begin
                    state_d = push_first;
                end
            end
            StPushPrev: begin
                if (g2l_dep_ready) begin
                    state_d = push_next ? StPushNext : StIdle;
                end
            end
            StPushNext: begin
                if (g2s_dep_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && state_d == StIdle) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            insn_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            insn_q  <= insn_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; insn_ready is additionally gated by rst.
    assign insn_ready    = (state_q == StIdle) & ~rst;
    assign l2g_dep_ready = (state_q == StPopPrev);
    assign s2g_dep_ready = (state_q == StPopNext);
    assign g2l_dep_valid = (state_q == StPushPrev);
    assign g2s_dep_valid = (state_q == StPushNext);
    assign gemm_start    = (state_q == StExec) && (opcode == OpGemm);
    assign finish        = (state_q == StExec) && (opcode == OpFinish);
    assign gemm_insn     = insn_q;
    assign err_opcode    = err_q;
    assign insn_cnt      = cnt_q;

endmodule

// File: tb/tb_gemm_dispatch.sv
// Directed self-checking bench for gemm_dispatch; a second narrow-counter instance
// shares all stimulus so that counter wrap is reached in few instructions.
module tb_gemm_dispatch;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] insn_in;
    logic         insn_valid;
    logic         insn_ready;
    logic         l2g_dep_valid, l2g_dep_ready;
    logic         s2g_dep_valid, s2g_dep_ready;
    logic         g2l_dep_valid, g2l_dep_ready;
    logic         g2s_dep_valid, g2s_dep_ready;
    logic [127:0] gemm_insn;
    logic         gemm_start;
    logic         gemm_done;
    logic         finish;
    logic         err_opcode;
    logic [15:0]  insn_cnt;

    logic         s_insn_ready, s_l2g_ready, s_s2g_ready, s_g2l_valid, s_g2s_valid;
    logic [127:0] s_gemm_insn;
    logic         s_gemm_start, s_finish, s_err;
    logic [3:0]   s_cnt;

    int checks   = 0;
    int failures = 0;
    int starts   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gemm_start) starts <= starts + 1;
    end

    gemm_dispatch u_dut (
        .clk           (clk),
        .rst           (rst),
        .insn_in       (insn_in),
        .insn_valid    (insn_valid),
        .insn_ready    (insn_ready),
        .l2g_dep_valid (l2g_dep_valid),
        .l2g_dep_ready (l2g_dep_ready),
        .s2g_dep_valid (s2g_dep_valid),
        .s2g_dep_ready (s2g_dep_ready),
        .g2l_dep_valid (g2l_dep_valid),
        .g2l_dep_ready (g2l_dep_ready),
        .g2s_dep_valid (g2s_dep_valid),
        .g2s_dep_ready (g2s_dep_ready),
        .gemm_insn     (gemm_insn),
        .gemm_start    (gemm_start),
        .gemm_done     (gemm_done),
        .finish        (finish),
        .err_opcode    (err_opcode),
        .insn_cnt      (insn_cnt)
    );

    gemm_dispatch #(.CNT_WIDTH(4)) u_small (
        .clk           (clk),
        .rst           (rst),
        .insn_in       (insn_in),
        .insn_valid    (insn_valid),
        .insn_ready    (s_insn_ready),
        .l2g_dep_valid (l2g_dep_valid),
        .l2g_dep_ready (s_l2g_ready),
        .s2g_dep_valid (s2g_dep_valid),
        .s2g_dep_ready (s_s2g_ready),
        .g2l_dep_valid (s_g2l_valid),
        .g2l_dep_ready (g2l_dep_ready),
        .g2s_dep_valid (s_g2s_valid),
        .g2s_dep_ready (g2s_dep_ready),
        .gemm_insn     (s_gemm_insn),
        .gemm_start    (s_gemm_start),
        .gemm_done     (gemm_done),
        .finish        (s_finish),
        .err_opcode    (s_err),
        .insn_cnt      (s_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs the one-bit dependency/handshake outputs: {l2g_rdy,s2g_rdy,g2l_vld,g2s_vld}.
    function automatic logic [3:0] deps();
        return {l2g_dep_ready, s2g_dep_ready, g2l_dep_valid, g2s_dep_valid};
    endfunction

    initial begin
        rst = 1'b1;
        insn_in = '0;
        insn_valid = 1'b0;
        l2g_dep_valid = 1'b0;
        s2g_dep_valid = 1'b0;
        g2l_dep_ready = 1'b0;
        g2s_dep_ready = 1'b0;
        gemm_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_insn_ready", insn_ready, 0);
        chk("rst_gemm_insn", gemm_insn, 0);
        chk("rst_outs", {gemm_start, finish, err_opcode, deps()}, 0);
        chk("rst_cnt", insn_cnt, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", insn_ready, 1);

        // GEMM, no deps, done 5 cycles after start
        insn_in = 128'h02;
        insn_valid = 1'b1;
        step();
        insn_valid = 1'b0;
        chk("t1_start", gemm_start, 1);
        chk("t1_insn", gemm_insn, 128'h02);
        chk("t1_busy", insn_ready, 0);
        step();
        chk("t1_start_once", gemm_start, 0);
        repeat (3) step();
        gemm_done = 1'b1;
        step();
        gemm_done = 1'b0;
        chk("t1_ready_after_done", insn_ready, 1);
        chk("t1_cnt", insn_cnt, 1);
        chk("t1_starts", starts, 1);

        // All dep bits, delayed l2g and g2l handshakes
        insn_in = 128'h7A;
        insn_valid = 1'b1;
        step();
        insn_valid = 1'b0;
        chk("t2_pop_prev", deps(), 4'b1000);
        repeat (3) step();
        chk("t2_pop_prev_hold", deps(), 4'b1000);
        chk("t2_no_start_early", starts, 1);
        l2g_dep_valid = 1'b1;
        s2g_dep_valid = 1'b1;
        step();
        l2g_dep_valid = 1'b0;
        chk("t2_pop_next", deps(), 4'b0100);
        chk("t2_no_start_mid", gemm_start, 0);
        step();
        s2g_dep_valid = 1'b0;
        chk("t2_start", gemm_start, 1);
        step();
        gemm_done = 1'b1;
        step();
        gemm_done = 1'b0;
        chk("t2_push_prev", deps(), 4'b0010);
        repeat (2) step();
        chk("t2_push_prev_hold", deps(), 4'b0010);
        g2l_dep_ready = 1'b1;
        step();
        g2l_dep_ready = 1'b0;
        chk("t2_push_next", deps(), 4'b0001);
        g2s_dep_ready = 1'b1;
        step();
        g2s_dep_ready = 1'b0;
        chk("t2_idle", {insn_ready, deps()}, 5'b10000);
        chk("t2_cnt", insn_cnt, 2);
        chk("t2_starts", starts, 2);

        // FINISH with push_next
        insn_in = 128'h43;
        insn_valid = 1'b1;
        step();
        insn_valid = 1'b0;
        chk("t3_finish", {finish, gemm_start}, 2'b10);
        step();
        chk("t3_finish_once", finish, 0);
        chk("t3_g2s", deps(), 4'b0001);
        g2s_dep_ready = 1'b1;
        step();
        g2s_dep_ready = 1'b0;
        chk("t3_cnt", insn_cnt, 3);
        chk("t3_err", err_opcode, 0);
        chk("t3_starts", starts, 2);

        // Bad opcode 5 with pop_prev; spurious done in POP_PREV and IDLE
        insn_in = 128'h0D;
        insn_valid = 1'b1;
        step();
        insn_valid = 1'b0;
        gemm_done = 1'b1;
        step();
        gemm_done = 1'b0;
        chk("t4_done_ignored_pop", deps(), 4'b1000);
        l2g_dep_valid = 1'b1;
        step();
        l2g_dep_valid = 1'b0;
        chk("t4_no_start", {gemm_start, finish}, 2'b00);
        step();
        chk("t4_err", err_opcode, 1);
        chk("t4_cnt", insn_cnt, 4);
        gemm_done = 1'b1;
        step();
        gemm_done = 1'b0;
        chk("t4_done_ignored_idle", {insn_ready, deps(), insn_cnt}, {5'b10000, 16'd4});
        repeat (2) step();
        chk("t4_err_sticky", err_opcode, 1);

        // Async reset during WAIT
        insn_in = 128'h02;
        insn_valid = 1'b1;
        step();
        insn_valid = 1'b0;
        step();
        chk("t5_waiting", insn_ready, 0);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_cnt", insn_cnt, 0);
        chk("t5_rst_outs", {insn_ready, gemm_start, finish, err_opcode, deps()}, 0);
        chk("t5_rst_insn", gemm_insn, 0);
        step();
        rst = 1'b0;
        #1;
        chk("t5_ready", insn_ready, 1);

        // Back-to-back GEMMs with immediate done; small instance wraps at 16
        insn_in = 128'h02;
        for (int i = 0; i < 17; i++) begin
            insn_valid = 1'b1;
            step();
            insn_valid = (i < 16);
            step();
            gemm_done = 1'b1;
            step();
            gemm_done = 1'b0;
            if (i == 15) chk("t6_small_wrap0", s_cnt, 0);
        end
        chk("t6_cnt", insn_cnt, 17);
        chk("t6_small_cnt", s_cnt, 1);
        chk("t6_starts", starts, 20);
        chk("t6_idle", insn_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gemm_dispatch.md
# gemm_dispatch

Instruction dispatcher and dependency-token controller for the `gemm` core. It accepts 128-bit compute instructions through a valid/ready handshake and honours the four dependency-flag bits against the load→compute and store→compute token queues. It then drives the instruction into `gemm` with a start/done handshake and pushes the completion tokens back to load and store. It sits between the instruction-fetch FIFO and the `gemm` datapath.

## Interface
- INS_WIDTH, 128, instruction width; field layout is the team's standard insn format (opcode [2:0], pop_prev [3], pop_next [4], push_prev [5], push_next [6])
- CNT_WIDTH, 16, completed-instruction counter width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- insn_in  in  INS_WIDTH  instruction from fetch FIFO
- insn_valid  in  1  insn_in valid
- insn_ready  out  1  dispatcher can accept; = (state==IDLE) & ~rst
- l2g_dep_valid / l2g_dep_ready  in/out  1  pop token from load (pop_prev)
- s2g_dep_valid / s2g_dep_ready  in/out  1  pop token from store (pop_next)
- g2l_dep_valid / g2l_dep_ready  out/in  1  push token to load (push_prev)
- g2s_dep_valid / g2s_dep_ready  out/in  1  push token to store (push_next)
- gemm_insn  out  INS_WIDTH  registered instruction to `gemm`
- gemm_start  out  1  one-cycle pulse, starts `gemm`
- gemm_done  in  1  one-cycle pulse from `gemm`, execution complete
- finish  out  1  one-cycle pulse on FINISH opcode
- err_opcode  out  1  sticky; set on unsupported opcode
- insn_cnt  out  CNT_WIDTH  instructions retired, wraps modulo 2^CNT_WIDTH

## Operation
- States: IDLE, POP_PREV, POP_NEXT, EXEC, WAIT, PUSH_PREV, PUSH_NEXT.
- IDLE: on insn_valid & insn_ready, latch insn_in into gemm_insn. Next state is the first applicable of POP_PREV (bit3), POP_NEXT (bit4), EXEC.
- POP_PREV: l2g_dep_ready=1. On l2g_dep_valid, go to POP_NEXT if bit4, else EXEC.
- POP_NEXT: s2g_dep_ready=1. On s2g_dep_valid, go to EXEC.
- EXEC, opcode 3'h2 (GEMM): gemm_start=1 for exactly this cycle, then WAIT.
- EXEC, opcode 3'h3 (FINISH): finish=1 for this cycle, then push phase.
- EXEC, any other opcode: set err_opcode, no start, then push phase. Tokens are still popped and pushed so the queues stay balanced.
- WAIT: on gemm_done, go to push phase.
- Push phase: PUSH_PREV if bit5, else PUSH_NEXT if bit6, else IDLE.
- PUSH_PREV: g2l_dep_valid=1 until g2l_dep_ready; then PUSH_NEXT if bit6, else IDLE. PUSH_NEXT works the same with g2s.
- insn_cnt increments on the transition back to IDLE.
- Pops are strictly sequential: prev before next. Pushes likewise.
- gemm_done outside WAIT is ignored.
- err_opcode clears only on rst.

## Timing
- Reset (async assert): state=IDLE. gemm_insn=0, gemm_start=0, finish=0, err_opcode=0, insn_cnt=0, all dep valid/ready=0, insn_ready=0 while rst is high.
- GEMM with no dep bits, accepted at edge T:
  - EXEC during cycle T+1, start pulse in that cycle.
  - WAIT from T+2.
  - gemm_done sampled at edge D puts IDLE in cycle D+1; insn_ready=1 that cycle.
  - Back-to-back acceptance is possible at D+1.
- Each pop/push state costs at least 1 cycle and holds indefinitely until the token handshake completes.
- gemm_insn is stable from the cycle after accept until the next accept. `gemm` may sample it on any cycle.
- Dep valid/ready outputs are combinational decodes of registered state only, with no input→output combinational path. insn_ready likewise, apart from gating by rst.
- rst asserted mid-operation: immediate return to IDLE. Any in-flight token or instruction is dropped, and `gemm` must be reset by the same rst.
- insn_cnt wraps from 0xFFFF to 0x0000.

## Test plan
- Reset then GEMM insn (opcode 2, deps 0), gemm_done 5 cycles after start → exactly one start pulse one cycle after accept; insn_ready high the cycle after done; insn_cnt=1.
- Insn with bits 3,4,5,6 set; l2g_dep_valid delayed 3 cycles, s2g immediate, g2l_ready delayed 2 → order is pop_prev, pop_next, start, done, push_prev, push_next. No start before both pops complete.
- FINISH (opcode 3) with push_next → finish pulse 1 cycle, no gemm_start, one g2s token, err_opcode=0.
- Opcode 3'h5 with pop_prev → token consumed, err_opcode=1 and stays 1, no start, insn_cnt increments.
- Spurious gemm_done in IDLE and POP_PREV → no state change. Async rst pulse during WAIT → all outputs at reset values within the same cycle, insn_cnt=0.
- 65537 back-to-back GEMM insns with immediate done → insn_cnt=1 after wrap.
